img_fetch: RTL and testbench

Parametrised multi-channel image loader for the CNN accelerator. On `start` it reads an N×N×C feature map word-by-word from the DMA memory port, optionally surrounds each channel with a zero border of 0–2 pixels, and streams the result into the layer input buffer through a single write port. It replaces fixed-size, single-channel loading with runtime size, channel count and padding, a request/grant/valid memory handshake, and a configuration error check.

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/pix_counter.sv | 77 +++++++
 rtl/img_fetch.sv | 176 +++++++++++++++++
 tb/tb_img_fetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// ------------------------------------------------------------------
// cnn_pkg : shared widths and FSM encoding for the CNN loaders (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

package cnn_pkg;

    localparam int CNN_DATA_WIDTH = 16;
    localparam int CNN_ADDR_WIDTH = 20;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } img_fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pix_counter.sv
// ------------------------------------------------------------------
// pix_counter : channel/row/column walker over a padded W x W x C map (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module pix_counter
    import cnn_pkg::*;
#(
    parameter int CNT_W = 7,
    parameter int CH_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             step_i,
    input  logic [CNT_W-1:0] size_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [1:0]       pad_i,
    input  logic [CH_W-1:0]  nch_i,
    output logic             is_pad_o,
    output logic             last_o
);

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             w_col_end, w_row_end, w_ch_end;
    logic [CNT_W-1:0] w_lo, w_hi;

    assign w_lo      = CNT_W'(pad_i);
    assign w_hi      = w_lo + size_i;
    assign w_col_end = (col_q == width_i - CNT_W'(1));
    assign w_row_end = (row_q == width_i - CNT_W'(1));
    assign w_ch_end  = (ch_q == nch_i - CH_W'(1));

    // Interior window is [P0, P0+N) on both axes.
    assign is_pad_o = (row_q < w_lo) || (row_q >= w_hi) || (col_q < w_lo) || (col_q >= w_hi);
    assign last_o   = w_col_end && w_row_end && w_ch_end;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        ch_d  = ch_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
            ch_d  = '0;
        end else if (step_i) begin
            if (w_col_end) begin
                col_d = '0;
                if (w_row_end) begin
                    row_d = '0;
                    ch_d  = w_ch_end ? '0 : ch_q + CH_W'(1);
                end else begin
                    row_d = row_q + CNT_W'(1);
                end
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            ch_q  <= ch_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/img_fetch.sv
// ------------------------------------------------------------------
// img_fetch : runtime-sized, zero-padded multi-channel feature-map loader (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module img_fetch
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int ADDR_WIDTH = CNN_ADDR_WIDTH,
    parameter int MAX_IMG    = 32,
    parameter int MAX_CH     = 8,
    parameter int BUF_DEPTH  = 8192
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [5:0]                   img_size,
    input  logic [$clog2(MAX_CH+1)-1:0]  num_ch,
    input  logic [1:0]                   pad,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    output logic                         mem_req,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic                         buf_we,
    output logic [$clog2(BUF_DEPTH)-1:0] buf_addr,
    output logic [DATA_WIDTH-1:0]        buf_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int BUF_AW = $clog2(BUF_DEPTH);
    localparam int CH_W   = $clog2(MAX_CH + 1);
    localparam int CNT_W  = 7;

    img_fetch_state_t      state_q, state_d;
    logic [CNT_W-1:0]      n_q, w_q;
    logic [1:0]            p_q;
    logic [CH_W-1:0]       c_q;
    logic [ADDR_WIDTH-1:0] mem_ptr_q;
    logic [BUF_AW-1:0]     buf_ptr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  wr_pend_q, wr_pend_d;
    logic                  fin_q, fin_d;
    logic                  err_q, err_d;

    logic                  w_step, w_is_pad, w_last;
    logic                  w_accept, w_illegal, w_pad_we, w_grant, w_take;
    logic [CNT_W-1:0]      w_n, w_w;
    logic [31:0]           w_total;

    assign w_n     = CNT_W'(img_size);
    assign w_w     = w_n + CNT_W'({pad, 1'b0});
    assign w_total = 32'(num_ch) * 32'(w_w) * 32'(w_w);

    assign w_illegal = (img_size == '0) || (32'(img_size) > 32'(MAX_IMG))
                    || (num_ch == '0) || (32'(num_ch) > 32'(MAX_CH))
                    || (pad == 2'd3) || (w_total > 32'(BUF_DEPTH));

    assign w_accept = (state_q == ST_IDLE) && start && !w_illegal;
    assign w_grant  = (state_q == ST_REQ) && mem_gnt;
    assign w_take   = (state_q == ST_WAIT) && mem_rvalid;
    // A returned word owns the write port for one cycle; a pad pixel then waits.
    assign w_pad_we = (state_q == ST_SCAN) && !fin_q && !wr_pend_q && w_is_pad;

    assign mem_req   = (state_q == ST_REQ);
    assign mem_addr  = mem_req ? mem_ptr_q : '0;
    assign buf_we    = wr_pend_q || w_pad_we;
    assign buf_addr  = buf_ptr_q;
    assign buf_wdata = wr_pend_q ? rdata_q : '0;
    assign busy      = (state_q == ST_SCAN) || (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

    pix_counter #(
        .CNT_W (CNT_W),
        .CH_W  (CH_W)
    ) u_pix_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (w_accept),
        .step_i   (w_step),
        .size_i   (n_q),
        .width_i  (w_q),
        .pad_i    (p_q),
        .nch_i    (c_q),
        .is_pad_o (w_is_pad),
        .last_o   (w_last)
    );

    // fin_q marks that the counter has issued its last pixel, which was an
    // interior one still waiting for its data to be written.
    always_comb begin
        state_d   = state_q;
        wr_pend_d = 1'b0;
        fin_d     = fin_q;
        err_d     = 1'b0;
        w_step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (w_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_SCAN;
                        fin_d   = 1'b0;
                    end
                end
            end
            ST_SCAN: begin
                if (fin_q) begin
                    state_d = ST_DONE;
                end else if (w_is_pad) begin
                    if (!wr_pend_q) begin
                        w_step = 1'b1;
                        if (w_last) state_d = ST_DONE;
                    end
                end else begin
                    w_step  = 1'b1;
                    fin_d   = w_last;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    wr_pend_d = 1'b1;
                    state_d   = ST_SCAN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_pend_q <= 1'b0;
            fin_q     <= 1'b0;
            err_q     <= 1'b0;
            n_q       <= '0;
            w_q       <= '0;
            p_q       <= '0;
            c_q       <= '0;
            mem_ptr_q <= '0;
            buf_ptr_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_pend_q <= wr_pend_d;
            fin_q     <= fin_d;
            err_q     <= err_d;
            if (w_accept) begin
                n_q       <= w_n;
                w_q       <= w_w;
                p_q       <= pad;
                c_q       <= CH_W'(num_ch);
                mem_ptr_q <= base_addr;
                buf_ptr_q <= '0;
            end else begin
                if (w_grant) mem_ptr_q <= mem_ptr_q + ADDR_WIDTH'(1);
                if (buf_we)  buf_ptr_q <= buf_ptr_q + BUF_AW'(1);
            end
            if (w_take) rdata_q <= mem_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_img_fetch.sv
// ------------------------------------------------------------------
// tb_img_fetch : randomized self-checking bench for img_fetch (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module tb_img_fetch;

    localparam int DW  = 16;
    localparam int AW  = 20;
    localparam int BD  = 8192;
    localparam int BAW = 13;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [5:0]     img_size = '0;
    logic [CW-1:0]  num_ch = '0;
    logic [1:0]     pad = '0;
    logic [AW-1:0]  base_addr = '0;
    logic           mem_req;
    logic [AW-1:0]  mem_addr;
    logic           mem_gnt = 1'b0;
    logic           mem_rvalid = 1'b0;
    logic [DW-1:0]  mem_rdata = '0;
    logic           buf_we;
    logic [BAW-1:0] buf_addr;
    logic [DW-1:0]  buf_wdata;
    logic           busy, done, err;

    img_fetch #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_IMG    (32),
        .MAX_CH     (8),
        .BUF_DEPTH  (BD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .img_size   (img_size),
        .num_ch     (num_ch),
        .pad        (pad),
        .base_addr  (base_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_wdata  (buf_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observed traffic
    logic [31:0]   wq[$];
    logic [AW-1:0] aq[$];
    int done_n, err_n, busy_n, req_n, coll, unstable, done_cyc, err_cyc, last_wr_cyc;

    // Memory model knobs and state
    int            g_lo, g_hi, r_lo, r_hi, cur_gd, cur_rd, rv_cnt, req_wait;
    bit            noise, outst, prev_wait;
    logic [15:0]   key;
    logic [AW-1:0] lat_addr, prev_addr;

    function automatic logic [15:0] mdata(input logic [AW-1:0] a);
        return a[15:0] ^ key;
    endfunction

    function automatic longint outs_now();
        return longint'({mem_req, mem_addr, buf_we, buf_addr, buf_wdata, busy, done, err});
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        aq.delete();
        done_n = 0; err_n = 0; busy_n = 0; req_n = 0;
        coll = 0; unstable = 0; done_cyc = -1; err_cyc = -1; last_wr_cyc = -1;
    endtask

    // Monitor samples outputs at the falling edge, then the memory responds.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                outst = 0; rv_cnt = 0; req_wait = 0; prev_wait = 0;
                mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            end else begin
                if (buf_we) begin
                    wq.push_back({3'b000, buf_addr, buf_wdata});
                    last_wr_cyc = cyc;
                    if (done || err) coll++;
                end
                if (done) begin done_n++; done_cyc = cyc; end
                if (err) begin err_n++; err_cyc = cyc; end
                if (busy) busy_n++;
                if (mem_req) req_n++;

                mem_rvalid = 1'b0;
                mem_rdata  = DW'($urandom);
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mdata(lat_addr);
                        outst      = 0;
                    end
                end else if (!outst && noise && $urandom_range(3, 0) == 0) begin
                    mem_rvalid = 1'b1;
                end

                mem_gnt = 1'b0;
                if (mem_req && !outst) begin
                    if (prev_wait && mem_addr !== prev_addr) unstable++;
                    if (req_wait >= cur_gd) begin
                        mem_gnt   = 1'b1;
                        aq.push_back(mem_addr);
                        lat_addr  = mem_addr;
                        outst     = 1;
                        rv_cnt    = cur_rd + 1;
                        req_wait  = 0;
                        prev_wait = 0;
                        cur_gd    = int'($urandom_range(g_hi, g_lo));
                        cur_rd    = int'($urandom_range(r_hi, r_lo));
                    end else begin
                        req_wait++;
                        prev_wait = 1;
                        prev_addr = mem_addr;
                    end
                end else begin
                    prev_wait = 0;
                    if (!mem_req && noise && $urandom_range(3, 0) == 0) mem_gnt = 1'b1;
                end
            end
        end
    end

    task automatic run_job(input int n, input int c, input int p, input logic [AW-1:0] base,
                           input int glo, input int ghi, input int rlo, input int rhi,
                           input bit nz, input bit inj, input int exp_lat);
        int w, total, sc, limit, idx;
        bit legal, b1;
        logic [AW-1:0] ptr, ea;
        logic [15:0] ed;
        logic [31:0] ew;
        w     = n + 2 * p;
        total = c * w * w;
        legal = (n >= 1) && (n <= 32) && (c >= 1) && (c <= 8) && (p <= 2) && (total <= BD);
        limit = legal ? total * 14 + 200 : 50;
        clear_mon();
        g_lo = glo; g_hi = ghi; r_lo = rlo; r_hi = rhi; noise = nz;
        cur_gd = int'($urandom_range(ghi, glo));
        cur_rd = int'($urandom_range(rhi, rlo));

        @(negedge clk); #1;
        img_size = 6'(n); num_ch = CW'(c); pad = 2'(p); base_addr = base; start = 1'b1;
        sc = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        img_size = 6'($urandom); num_ch = CW'($urandom); pad = 2'($urandom); base_addr = AW'($urandom);
        b1 = busy;
        for (int i = 0; i < limit; i++) begin
            if (done_n != 0 || err_n != 0) break;
            if (inj && i == 10 && busy) begin
                start = 1'b1; img_size = 6'd3; pad = 2'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk); #1;
        end
        start = 1'b0;
        chk("job_ended", longint'(done_n + err_n != 0), 1);
        repeat (6) @(negedge clk);
        #1;

        if (legal) begin
            chk("busy_after_start", longint'(b1), 1);
            chk("done_count", done_n, 1);
            chk("err_count", err_n, 0);
            chk("write_count", wq.size(), total);
            chk("read_count", aq.size(), c * n * n);
            chk("done_after_last_write", done_cyc, last_wr_cyc + 1);
            chk("we_with_done", coll, 0);
            chk("addr_stable_while_req", unstable, 0);
            if (exp_lat > 0) chk("zero_latency_cycles", done_cyc - sc, exp_lat);
            idx = 0;
            ptr = base;
            for (int ch = 0; ch < c; ch++)
                for (int r = 0; r < w; r++)
                    for (int col = 0; col < w; col++) begin
                        if (r < p || r >= p + n || col < p || col >= p + n) begin
                            ed = '0;
                        end else begin
                            ed  = mdata(ptr);
                            ptr = ptr + AW'(1);
                        end
                        ew = {3'b000, BAW'(idx), ed};
                        if (idx < wq.size()) chk("buf_write", wq[idx], ew);
                        idx++;
                    end
            for (int i = 0; i < c * n * n; i++) begin
                ea = base + AW'(i);
                if (i < aq.size()) chk("mem_addr_seq", aq[i], ea);
            end
        end else begin
            chk("err_count", err_n, 1);
            chk("err_timing", err_cyc, sc + 1);
            chk("busy_after_bad_start", longint'(b1), 0);
            chk("busy_cycles", busy_n, 0);
            chk("req_cycles", req_n, 0);
            chk("write_count", wq.size(), 0);
            chk("done_count", done_n, 0);
        end
    endtask

    initial begin
        bit reached;
        key = '0; noise = 0; g_lo = 0; g_hi = 0; r_lo = 0; r_hi = 0;
        clear_mon();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", outs_now(), 0);
        rst_n = 1'b1;

        run_job(2, 1, 0, 20'h100, 0, 0, 0, 0, 0, 0, 14);
        run_job(2, 1, 1, 20'h100, 0, 0, 0, 0, 0, 0, 0);
        run_job(2, 3, 0, 20'h100, 0, 0, 0, 0, 0, 0, 0);
        run_job(2, 3, 1, 20'h100, 3, 3, 4, 4, 0, 1, 0);

        run_job(0, 1, 0, 20'h100, 0, 0, 0, 0, 0, 0, 0);
        run_job(2, 1, 3, 20'h100, 0, 0, 0, 0, 0, 0, 0);
        run_job(32, 8, 2, 20'h100, 0, 0, 0, 0, 0, 0, 0);
        run_job(33, 1, 0, 20'h100, 0, 0, 0, 0, 0, 0, 0);
        run_job(4, 0, 0, 20'h100, 0, 0, 0, 0, 0, 0, 0);
        run_job(4, 9, 0, 20'h100, 0, 0, 0, 0, 0, 0, 0);

        run_job(1, 1, 2, 20'h040, 0, 1, 0, 2, 0, 0, 0);
        run_job(32, 8, 0, 20'h000, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            key = 16'($urandom);
            run_job(int'($urandom_range(8, 1)), int'($urandom_range(3, 1)), int'($urandom_range(2, 0)),
                    AW'($urandom), 0, 3, 0, 4, 1, 0, 0);
        end
        key = 16'($urandom);
        run_job(3, 2, 1, 20'hFFFFC, 0, 2, 0, 3, 1, 0, 0);

        // Abandon a transfer while a read is outstanding.
        key = '0; noise = 0; g_lo = 0; g_hi = 0; r_lo = 6; r_hi = 6; cur_gd = 0; cur_rd = 6;
        clear_mon();
        @(negedge clk); #1;
        img_size = 6'd3; num_ch = CW'(1); pad = 2'd0; base_addr = 20'h200; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        reached = 0;
        for (int i = 0; i < 100; i++) begin
            if (aq.size() >= 2 && busy && !mem_req) begin
                reached = 1;
                break;
            end
            @(negedge clk); #1;
        end
        chk("reached_wait", longint'(reached), 1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_wait", outs_now(), 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("no_done_after_reset", done_n, 0);
        run_job(3, 1, 0, 20'h200, 0, 1, 0, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
